// File: rtl/beep_pkg.sv
// Shared types and sizing helpers for the beep sequencer.
package beep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold max_val-1; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
import beep_pkg::*;

module phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Reload wins over counting; the count holds at zero instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == {W{1'b0}});

endmodule

// File: rtl/beep_sequencer.sv
// Turns trigger pulses into timed on/off bursts for a buzzer or LED.
// Optional abort input enabled by defining BEEP_CANCEL_EN.
import beep_pkg::*;

module beep_sequencer #(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 25_000_000,
    parameter int BEEPS      = 3,
    parameter int PEND_MAX   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
`ifdef BEEP_CANCEL_EN
    input  logic cancel,
`endif
    output logic level_out,
    output logic busy,
    output logic drop
);

    localparam int CNT_W  = cnt_width(max_of(ON_CYCLES, OFF_CYCLES));
    localparam int BEEP_W = cnt_width(BEEPS);
    localparam int PEND_W = $clog2(PEND_MAX + 1);

    localparam logic [CNT_W-1:0]  ON_LOAD   = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LOAD  = CNT_W'(OFF_CYCLES - 1);
    localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEPS - 1);
    localparam logic [BEEP_W-1:0] BEEP_ONE  = BEEP_W'(1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    state_t            state_q, state_d;
    logic [BEEP_W-1:0] beep_q, beep_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              drop_q, drop_d;
    logic              level_q, level_d;
    logic              busy_q, busy_d;

    logic              tmr_load_s, tmr_en_s, tmr_done_s;
    logic [CNT_W-1:0]  tmr_val_s;
    logic              start_s, q_inc_s, q_dec_s, cancel_s;

`ifdef BEEP_CANCEL_EN
    assign cancel_s = cancel;
`else
    assign cancel_s = 1'b0;
`endif

    phase_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .en       (tmr_en_s),
        .done     (tmr_done_s)
    );

    // Next-state, counters and queue bookkeeping.
    always_comb begin
        state_d    = state_q;
        beep_d     = beep_q;
        pend_d     = pend_q;
        drop_d     = 1'b0;
        tmr_load_s = 1'b0;
        tmr_val_s  = {CNT_W{1'b0}};
        tmr_en_s   = 1'b0;
        start_s    = 1'b0;
        q_inc_s    = 1'b0;
        q_dec_s    = 1'b0;

        case (state_q)
            IDLE: begin
                start_s = trig;
            end
            ON: begin
                tmr_en_s = 1'b1;
                q_inc_s  = trig;
                if (tmr_done_s) begin
                    state_d    = OFF;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = OFF_LOAD;
                end else begin
                    state_d = ON;
                end
            end
            OFF: begin
                tmr_en_s = 1'b1;
                if (!tmr_done_s) begin
                    q_inc_s = trig;
                end else if (beep_q != {BEEP_W{1'b0}}) begin
                    q_inc_s    = trig;
                    beep_d     = beep_q - BEEP_ONE;
                    state_d    = ON;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = ON_LOAD;
                end else if (pend_q != {PEND_W{1'b0}}) begin
                    q_inc_s = trig;
                    q_dec_s = 1'b1;
                    start_s = 1'b1;
                end else if (trig) begin
                    // Trig at burst end with nothing queued starts the next burst directly.
                    start_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_s) begin
            state_d    = ON;
            beep_d     = BEEP_LOAD;
            tmr_load_s = 1'b1;
            tmr_val_s  = ON_LOAD;
        end else begin
            beep_d = beep_d;
        end

        if (q_inc_s && !q_dec_s) begin
            if (pend_q == PEND_FULL) begin
                drop_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (q_dec_s && !q_inc_s) begin
            pend_d = pend_q - PEND_ONE;
        end else begin
            pend_d = pend_q;
        end

        // Abort overrides everything, including a same-cycle trig.
        if (cancel_s) begin
            state_d    = IDLE;
            beep_d     = {BEEP_W{1'b0}};
            pend_d     = {PEND_W{1'b0}};
            drop_d     = 1'b0;
            tmr_load_s = 1'b1;
            tmr_val_s  = {CNT_W{1'b0}};
        end else begin
            state_d = state_d;
        end

        level_d = (state_d == ON);
        busy_d  = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beep_q  <= {BEEP_W{1'b0}};
            pend_q  <= {PEND_W{1'b0}};
            drop_q  <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beep_q  <= beep_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    assign level_out = level_q;
    assign busy      = busy_q;
    assign drop      = drop_q;

endmodule
